pong_game_ctrl: RTL
===================

// Module: pong_game_ctrl
// PURPOSE
//  Game-state controller for the Pong display path. Sits beside the VGA sync generator on clk25,
//  watches hc/vc to derive one update tick per frame, and sequences ball motion, paddle motion,
//  collisions and scoring. Outputs object positions, scores and game state to the pixel renderer.
//  All state changes occur during vertical blank, so no mid-frame tearing.
// PARAMETERS
//  H_VIS      640  visible columns
//  V_VIS      480  visible rows
//  BALL_SZ    8    ball edge length, pixels
//  PAD_W      8    paddle width
//  PAD_H      64   paddle height
//  PAD_XL     16   left paddle left edge x
//  PAD_XR     616  right paddle left edge x
//  BALL_SPD   2    ball step per frame, each axis
//  PAD_SPD    4    paddle step per frame
//  WIN_SCORE  9    score ending the game (max 15)
//  HOLD_FR    60   frames held in SCORED
// PORTS
//  clk        in   1   pixel clock (25 MHz)
//  clr        in   1   synchronous active-high reset
//  hc         in   10  horizontal counter from sync generator
//  vc         in   10  vertical counter from sync generator
//  btn_lu     in   1   left paddle up (async, raw)
//  btn_ld     in   1   left paddle down (async, raw)
//  btn_ru     in   1   right paddle up (async, raw)
//  btn_rd     in   1   right paddle down (async, raw)
//  btn_srv    in   1   serve / restart (async, raw)
//  frame_tick out  1   one-cycle pulse, registered, when hc==0 && vc==V_VIS
//  ball_x     out  10  ball left edge
//  ball_y     out  10  ball top edge
//  padl_y     out  10  left paddle top edge
//  padr_y     out  10  right paddle top edge
//  score_l    out  4   left score
//  score_r    out  4   right score
//  state      out  2   SERVE=0 PLAY=1 SCORED=2 GAMEOVER=3
// BEHAVIOUR
//  Reset (clr wins over all): state SERVE, scores 0, frame_tick 0, ball (316,236), dx=+, dy=+,
//   pads 208, hold counter 0, serve pending 0, sync flops 0.
//  Buttons: 2-FF synchronizer each. Serve: rising edge of synced btn_srv sets srv_pend; cleared
//   on the tick that consumes it, and on every tick in PLAY/SCORED (no stale serves).
//  Every update happens only in the cycle frame_tick==1; outputs change the cycle after.
//  Paddles (all states but GAMEOVER): up-only -> y-=PAD_SPD clamped at 0; down-only -> y+=PAD_SPD
//   clamped at V_VIS-PAD_H; both or neither -> hold.
//  SERVE: ball held at centre; srv_pend -> PLAY.
//  PLAY, vertical: next y<=0 -> y=0, dy=+; next y>=V_VIS-BALL_SZ -> clamp, dy=-.
//  PLAY, horizontal (independent of vertical, uses pre-update paddle y): dx=- and next x<=PAD_XL+PAD_W
//   and x>=PAD_XL+PAD_W and y-overlap (ball_y+BALL_SZ>pad_y && ball_y<pad_y+PAD_H) -> x=PAD_XL+PAD_W, dx=+.
//   Mirror for right: face at PAD_XR-BALL_SZ. Paddle check precedes wall check.
//   next x<=0 -> score_r+1, SCORED; next x>=H_VIS-BALL_SZ -> score_l+1, SCORED. Scores saturate.
//  SCORED: ball frozen; hold counter counts ticks; at HOLD_FR: either score==WIN_SCORE -> GAMEOVER,
//   else SERVE with ball centred and dx toward the player who conceded.
//  GAMEOVER: ball/pads frozen; srv_pend -> scores 0, pads centred, SERVE.
//  Arithmetic in 11-bit signed temporaries to detect underflow before clamping.
// STRUCTURE
//  pong_defs.vh: state encodings, default geometry constants, shared with the renderer.
//  Sub-module btn_sync: 2-FF synchronizer + rising-edge pulse, instanced 5x.
// TESTING
//  clr held 2 cycles mid-PLAY -> all outputs at reset values next cycle, state=0.
//  SERVE, pulse btn_srv 3 cycles -> state=1 after next frame_tick; ball advances (+2,+2)/frame.
//  Ball y=2, dy=- -> next tick y=0, dy=+; following tick y=2.
//  Ball x=26,dx=-, padl_y=200, ball_y=230 -> x=24, dx=+; with padl_y=300 -> ball exits, score_r=1, state=2.
//  btn_lu+btn_ld together -> padl_y unchanged; btn_lu at padl_y=2 -> 0, stays 0.
//  score_l=8, left scores -> 9, after 60 ticks state=3; btn_srv -> scores 0, state=0.

Source files
------------

// File: rtl/pong_game_ctrl_pkg.sv
// Shared geometry, state encodings and small arithmetic helpers for the Pong game controller.
package pong_game_ctrl_pkg;

    localparam int unsigned H_VIS     = 640;
    localparam int unsigned V_VIS     = 480;
    localparam int unsigned BALL_SZ   = 8;
    localparam int unsigned PAD_W     = 8;
    localparam int unsigned PAD_H     = 64;
    localparam int unsigned PAD_XL    = 16;
    localparam int unsigned PAD_XR    = 616;
    localparam int unsigned BALL_SPD  = 2;
    localparam int unsigned PAD_SPD   = 4;
    localparam int unsigned WIN_SCORE = 9;
    localparam int unsigned HOLD_FR   = 60;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned HOLD_W  = $clog2(HOLD_FR);
    localparam int unsigned SCOORD_W = COORD_W + 1;

    // Home positions: ball centred on screen, paddles centred vertically
    localparam int unsigned BALL_X0 = (H_VIS - BALL_SZ) / 2;
    localparam int unsigned BALL_Y0 = (V_VIS - BALL_SZ) / 2;
    localparam int unsigned PAD_Y0  = (V_VIS - PAD_H) / 2;

    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_SCORED   = 2'd2,
        ST_GAMEOVER = 2'd3
    } game_state_e;

    // Synchronised button bundle
    typedef struct packed {
        logic lu;
        logic ld;
        logic ru;
        logic rd;
        logic srv;
    } btn_t;

    // One extra bit so a step past zero shows up as negative before clamping
    typedef logic signed [SCOORD_W-1:0] scoord_t;

    localparam scoord_t S_ZERO      = scoord_t'(0);
    localparam scoord_t S_BALL_SPD  = scoord_t'(BALL_SPD);
    localparam scoord_t S_PAD_SPD   = scoord_t'(PAD_SPD);
    localparam scoord_t S_BALL_SZ   = scoord_t'(BALL_SZ);
    localparam scoord_t S_PAD_H     = scoord_t'(PAD_H);
    localparam scoord_t S_PAD_YMAX  = scoord_t'(V_VIS - PAD_H);
    localparam scoord_t S_BALL_YMAX = scoord_t'(V_VIS - BALL_SZ);
    localparam scoord_t S_BALL_XMAX = scoord_t'(H_VIS - BALL_SZ);
    localparam scoord_t S_FACE_L    = scoord_t'(PAD_XL + PAD_W);
    localparam scoord_t S_FACE_R    = scoord_t'(PAD_XR - BALL_SZ);

    // Zero-extend a screen coordinate into the signed working width
    function automatic scoord_t to_s(input logic [COORD_W-1:0] v);
        return scoord_t'({1'b0, v});
    endfunction

    // One frame of paddle motion; opposing or idle buttons hold position
    function automatic logic [COORD_W-1:0] pad_step(input logic [COORD_W-1:0] y,
                                                    input logic up, input logic dn);
        scoord_t t;
        t = to_s(y);
        if (up && !dn) begin
            t = t - S_PAD_SPD;
            if (t < S_ZERO) t = S_ZERO;
        end else if (dn && !up) begin
            t = t + S_PAD_SPD;
            if (t > S_PAD_YMAX) t = S_PAD_YMAX;
        end
        return COORD_W'(t);
    endfunction

    // Score increment that sticks at the counter maximum
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_btn_sync.sv
// Two-flop synchroniser for a raw push button, registered level or rising-edge pulse out.
module pong_game_ctrl_btn_sync
    import pong_game_ctrl_pkg::*;
#(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_i,
    output logic out_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic out_q;

    // Synchronise, keep one stage of history, register the selected output
    always_ff @(posedge clk) begin
        if (clr) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            out_q  <= EDGE ? (sync_q & ~prev_q) : sync_q;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: one update per frame during vertical blank.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic [COORD_W-1:0]   hc,
    input  logic [COORD_W-1:0]   vc,
    input  logic                 btn_lu,
    input  logic                 btn_ld,
    input  logic                 btn_ru,
    input  logic                 btn_rd,
    input  logic                 btn_srv,
    output logic                 frame_tick,
    output logic [COORD_W-1:0]   ball_x,
    output logic [COORD_W-1:0]   ball_y,
    output logic [COORD_W-1:0]   padl_y,
    output logic [COORD_W-1:0]   padr_y,
    output logic [SCORE_W-1:0]   score_l,
    output logic [SCORE_W-1:0]   score_r,
    output logic [1:0]           state
);

    btn_t btn_s;

    pong_game_ctrl_btn_sync #(.EDGE(1'b0)) u_sync_lu  (.clk(clk), .clr(clr), .btn_i(btn_lu),  .out_o(btn_s.lu));
    pong_game_ctrl_btn_sync #(.EDGE(1'b0)) u_sync_ld  (.clk(clk), .clr(clr), .btn_i(btn_ld),  .out_o(btn_s.ld));
    pong_game_ctrl_btn_sync #(.EDGE(1'b0)) u_sync_ru  (.clk(clk), .clr(clr), .btn_i(btn_ru),  .out_o(btn_s.ru));
    pong_game_ctrl_btn_sync #(.EDGE(1'b0)) u_sync_rd  (.clk(clk), .clr(clr), .btn_i(btn_rd),  .out_o(btn_s.rd));
    pong_game_ctrl_btn_sync #(.EDGE(1'b1)) u_sync_srv (.clk(clk), .clr(clr), .btn_i(btn_srv), .out_o(btn_s.srv));

    game_state_e          state_q, state_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [COORD_W-1:0]   ball_x_q, ball_x_d;
    logic [COORD_W-1:0]   ball_y_q, ball_y_d;
    logic                 dx_q, dx_d;
    logic                 dy_q, dy_d;
    logic [COORD_W-1:0]   padl_q, padl_d;
    logic [COORD_W-1:0]   padr_q, padr_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d;
    logic [SCORE_W-1:0]   score_r_q, score_r_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 srv_pend_q, srv_pend_d;
    logic                 lconc_q, lconc_d;

    scoord_t nx, ny, bx, by, pl, pr;
    logic    hit_l, hit_r;

    // Frame tick marks the first pixel of vertical blank
    assign frame_tick_d = (hc == '0) && (vc == COORD_W'(V_VIS));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_SERVE;
            frame_tick_q <= 1'b0;
            ball_x_q     <= COORD_W'(BALL_X0);
            ball_y_q     <= COORD_W'(BALL_Y0);
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            padl_q       <= COORD_W'(PAD_Y0);
            padr_q       <= COORD_W'(PAD_Y0);
            score_l_q    <= '0;
            score_r_q    <= '0;
            hold_q       <= '0;
            srv_pend_q   <= 1'b0;
            lconc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_tick_q <= frame_tick_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            padl_q       <= padl_d;
            padr_q       <= padr_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            hold_q       <= hold_d;
            srv_pend_q   <= srv_pend_d;
            lconc_q      <= lconc_d;
        end
    end

    // Next-state: everything holds except on the frame tick
    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        padl_d     = padl_q;
        padr_d     = padr_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        hold_d     = hold_q;
        srv_pend_d = srv_pend_q;
        lconc_d    = lconc_q;

        bx    = to_s(ball_x_q);
        by    = to_s(ball_y_q);
        pl    = to_s(padl_q);
        pr    = to_s(padr_q);
        nx    = dx_q ? (bx + S_BALL_SPD) : (bx - S_BALL_SPD);
        ny    = dy_q ? (by + S_BALL_SPD) : (by - S_BALL_SPD);
        hit_l = (by + S_BALL_SZ > pl) && (by < pl + S_PAD_H);
        hit_r = (by + S_BALL_SZ > pr) && (by < pr + S_PAD_H);

        if (frame_tick_q) begin
            if (state_q != ST_GAMEOVER) begin
                padl_d = pad_step(padl_q, btn_s.lu, btn_s.ld);
                padr_d = pad_step(padr_q, btn_s.ru, btn_s.rd);
            end

            case (state_q)
                ST_SERVE: begin
                    ball_x_d = COORD_W'(BALL_X0);
                    ball_y_d = COORD_W'(BALL_Y0);
                    if (srv_pend_q) begin
                        srv_pend_d = 1'b0;
                        state_d    = ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    srv_pend_d = 1'b0;
                    if (ny <= S_ZERO) begin
                        ball_y_d = '0;
                        dy_d     = 1'b1;
                    end else if (ny >= S_BALL_YMAX) begin
                        ball_y_d = COORD_W'(S_BALL_YMAX);
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = COORD_W'(ny);
                    end

                    if (!dx_q && nx <= S_FACE_L && bx >= S_FACE_L && hit_l) begin
                        ball_x_d = COORD_W'(S_FACE_L);
                        dx_d     = 1'b1;
                    end else if (dx_q && nx >= S_FACE_R && bx <= S_FACE_R && hit_r) begin
                        ball_x_d = COORD_W'(S_FACE_R);
                        dx_d     = 1'b0;
                    end else if (nx <= S_ZERO) begin
                        ball_x_d  = '0;
                        score_r_d = sat_inc(score_r_q);
                        lconc_d   = 1'b1;
                        hold_d    = '0;
                        state_d   = ST_SCORED;
                    end else if (nx >= S_BALL_XMAX) begin
                        ball_x_d  = COORD_W'(S_BALL_XMAX);
                        score_l_d = sat_inc(score_l_q);
                        lconc_d   = 1'b0;
                        hold_d    = '0;
                        state_d   = ST_SCORED;
                    end else begin
                        ball_x_d = COORD_W'(nx);
                    end
                end

                ST_SCORED: begin
                    srv_pend_d = 1'b0;
                    if (hold_q == HOLD_W'(HOLD_FR - 1)) begin
                        hold_d = '0;
                        if (score_l_q >= SCORE_W'(WIN_SCORE) || score_r_q >= SCORE_W'(WIN_SCORE)) begin
                            state_d = ST_GAMEOVER;
                        end else begin
                            state_d  = ST_SERVE;
                            ball_x_d = COORD_W'(BALL_X0);
                            ball_y_d = COORD_W'(BALL_Y0);
                            dx_d     = ~lconc_q;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end

                ST_GAMEOVER: begin
                    if (srv_pend_q) begin
                        srv_pend_d = 1'b0;
                        score_l_d  = '0;
                        score_r_d  = '0;
                        padl_d     = COORD_W'(PAD_Y0);
                        padr_d     = COORD_W'(PAD_Y0);
                        ball_x_d   = COORD_W'(BALL_X0);
                        ball_y_d   = COORD_W'(BALL_Y0);
                        state_d    = ST_SERVE;
                    end
                end

                default: begin
                    state_d = ST_SERVE;
                end
            endcase
        end

        // A fresh press is never lost, even when it lands on a tick
        if (btn_s.srv) srv_pend_d = 1'b1;
    end

    assign frame_tick = frame_tick_q;
    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign padl_y     = padl_q;
    assign padr_y     = padr_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign state      = state_q;

endmodule
